uart_receiver: RTL

- Serial-to-parallel receive half of the team's UART link: 8N1 frames (LSB first) on `rx_in`, recovered with 16x oversampling, delivered on a valid/ready holding register.
- Default build: 75 MHz receive clock, 1 156 000 baud.
- Sits at the far end of the link from the 50 MHz transmitter; reports framing errors and overruns to the consumer.

---
 rtl/uart_receiver_if.sv | 12 +
 rtl/uart_receiver.sv | 84 ++++++++
 2 files changed

// File: rtl/uart_receiver_if.sv
// uart_receiver_if: serial line plus valid/ready byte output and error pulses of the UART receiver
interface uart_receiver_if #(parameter int DATA_WIDTH = 8);
  logic rx_in;
  logic rx_ready;
  logic [DATA_WIDTH-1:0] rx_data;
  logic rx_valid;
  logic frame_err;
  logic overrun_err;
  logic rx_busy;
  modport master(input rx_in, rx_ready, output rx_data, rx_valid, frame_err, overrun_err, rx_busy);
  modport slave(output rx_in, rx_ready, input rx_data, rx_valid, frame_err, overrun_err, rx_busy);
endinterface

// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 UART receive path with oversampling and a valid/ready holding register; define RX_MAJORITY_VOTE_EN for 3-tick majority sampling
module uart_receiver #(
  parameter int BAUD_RATE  = 1156000,
  parameter int CLOCK_FREQ = 75000000,
  parameter int DATA_WIDTH = 8,
  parameter int OVERSAMPLE = 16
) (
  input logic r_clk,
  input logic r_rst,
  uart_receiver_if.master rx
);
  localparam int OSR_DIV = (CLOCK_FREQ + BAUD_RATE * OVERSAMPLE / 2) / (BAUD_RATE * OVERSAMPLE);
  localparam int DIV_W = OSR_DIV > 1 ? $clog2(OSR_DIV) : 1;
  localparam int SC_W = $clog2(OVERSAMPLE);
  localparam int BC_W = $clog2(DATA_WIDTH) + 1;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state;
  logic s1, rx_s, os_tick, samp;
  logic [DIV_W-1:0] div_cnt;
  logic [SC_W-1:0] sample_cnt;
  logic [BC_W-1:0] bit_cnt;
  logic [DATA_WIDTH-1:0] shreg;
  assign os_tick = div_cnt == DIV_W'(OSR_DIV - 1);
`ifdef RX_MAJORITY_VOTE_EN
  logic [1:0] hist;
  always_ff @(posedge r_clk) hist <= !r_rst ? 2'b11 : os_tick ? {hist[0], rx_s} : hist;
  assign samp = (rx_s & hist[0]) | (rx_s & hist[1]) | (hist[0] & hist[1]);
`else
  assign samp = rx_s;
`endif
  always_ff @(posedge r_clk) begin
    if (!r_rst) begin
      s1             <= 1'b1;
      rx_s           <= 1'b1;
      state          <= IDLE;
      div_cnt        <= '0;
      sample_cnt     <= '0;
      bit_cnt        <= '0;
      shreg          <= '0;
      rx.rx_data     <= '0;
      rx.rx_valid    <= 1'b0;
      rx.frame_err   <= 1'b0;
      rx.overrun_err <= 1'b0;
      rx.rx_busy     <= 1'b0;
    end else begin
      s1             <= rx.rx_in;
      rx_s           <= s1;
      rx.frame_err   <= 1'b0;
      rx.overrun_err <= 1'b0;
      if (rx.rx_valid && rx.rx_ready) rx.rx_valid <= 1'b0;
      div_cnt <= (state == IDLE || os_tick) ? '0 : div_cnt + 1'b1;
      if (os_tick && state != IDLE) sample_cnt <= sample_cnt + 1'b1;
      case (state)
        IDLE: if (!rx_s) begin
          state      <= START;
          sample_cnt <= '0;
          bit_cnt    <= '0;
          rx.rx_busy <= 1'b1;
        end
        START: if (os_tick && sample_cnt == SC_W'(OVERSAMPLE / 2 - 1)) begin
          sample_cnt <= '0;
          state      <= samp ? IDLE : DATA;
          rx.rx_busy <= !samp;
        end
        DATA: if (os_tick && sample_cnt == SC_W'(OVERSAMPLE - 1)) begin
          shreg   <= {samp, shreg[DATA_WIDTH-1:1]};
          bit_cnt <= bit_cnt + 1'b1;
          if (bit_cnt == BC_W'(DATA_WIDTH - 1)) state <= STOP;
        end
        STOP: if (os_tick && sample_cnt == SC_W'(OVERSAMPLE - 1)) begin
          // back to IDLE mid stop bit so a following start edge is not missed
          state      <= IDLE;
          rx.rx_busy <= 1'b0;
          if (!samp) rx.frame_err <= 1'b1;
          else if (!rx.rx_valid || rx.rx_ready) begin
            rx.rx_data  <= shreg;
            rx.rx_valid <= 1'b1;
          end else rx.overrun_err <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
